duty_scheduler: RTL and testbench

DUTY_SCHEDULER -- requirements
Module: duty_scheduler

---
 rtl/duty_scheduler_if.sv | 22 ++
 rtl/duty_scheduler.sv | 161 ++++++++++++++++
 tb/tb_duty_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/duty_scheduler_if.sv
// Control/status bundle between the duty scheduler and its surroundings.
// The master drives the request/strobe inputs; the slave (the scheduler) drives the status outputs.
interface duty_scheduler_if;
  logic       i_inc_req;
  logic       i_dec_req;
  logic       i_auto_en;
  logic       i_period_end;
  logic [3:0] o_duty;
  logic       o_duty_load;
  logic [2:0] o_state;
  logic [3:0] o_drop_cnt;

  modport master (
    output i_inc_req, i_dec_req, i_auto_en, i_period_end,
    input  o_duty, o_duty_load, o_state, o_drop_cnt
  );

  modport slave (
    input  i_inc_req, i_dec_req, i_auto_en, i_period_end,
    output o_duty, o_duty_load, o_state, o_drop_cnt
  );
endinterface

// File: rtl/duty_scheduler.sv
// PWM duty setpoint scheduler: manual +/-1 steps or an automatic triangle sweep, updated only at PWM period ends.
// Optional macro DUTY_SCHED_DROP_CNT_EN builds a saturating counter of dropped manual requests.
module duty_scheduler #(
  parameter int MAX_DUTY     = 10,
  parameter int INIT_DUTY    = 5,
  parameter int RAMP_PERIODS = 4,
  parameter int HOLD_PERIODS = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  duty_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PEND      = 3'd1,
    RAMP_UP   = 3'd2,
    HOLD      = 3'd3,
    RAMP_DOWN = 3'd4
  } state_t;

  localparam logic        [3:0] MAX_D  = 4'(MAX_DUTY);
  localparam logic        [3:0] INIT_D = 4'(INIT_DUTY);
  localparam logic        [3:0] RAMP_N = 4'(RAMP_PERIODS);
  localparam logic        [3:0] HOLD_N = 4'(HOLD_PERIODS);
  localparam logic signed [5:0] MAX_S  = 6'(MAX_DUTY);

  state_t            state;
  logic        [3:0] duty;
  logic signed [1:0] pend_step;
  logic        [3:0] per_cnt;
  logic              chg_p0;
  logic              load_p1;

  logic inc, dec, one_req, auto_en, period_end;

  assign inc        = bus.i_inc_req;
  assign dec        = bus.i_dec_req;
  assign one_req    = inc ^ dec;
  assign auto_en    = bus.i_auto_en;
  assign period_end = bus.i_period_end;

  function automatic logic [3:0] clamp_duty(input logic [3:0] d, input logic signed [1:0] s);
    logic signed [5:0] sum;
    sum = $signed({2'b00, d}) + $signed({{4{s[1]}}, s});
    if (sum < 6'sd0)       return 4'd0;
    else if (sum > MAX_S)  return MAX_D;
    else                   return sum[3:0];
  endfunction

  function automatic logic [3:0] cnt_next(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      duty      <= INIT_D;
      pend_step <= '0;
      per_cnt   <= '0;
      chg_p0    <= 1'b0;
      load_p1   <= 1'b0;
    end else begin
      chg_p0  <= 1'b0;
      load_p1 <= chg_p0;
      case (state)
        IDLE: begin
          if (auto_en) begin
            state     <= RAMP_UP;
            per_cnt   <= '0;
            pend_step <= '0;
          end else if (one_req) begin
            pend_step <= inc ? 2'sd1 : -2'sd1;
            state     <= PEND;
          end
        end
        PEND: begin
          if (auto_en) begin
            state     <= RAMP_UP;
            per_cnt   <= '0;
            pend_step <= '0;
          end else if (period_end) begin
            duty      <= clamp_duty(duty, pend_step);
            chg_p0    <= (clamp_duty(duty, pend_step) != duty);
            state     <= IDLE;
            pend_step <= '0;
          end
        end
        RAMP_UP: begin
          if (period_end) begin
            if (!auto_en) begin
              state   <= IDLE;
              per_cnt <= '0;
            end else if (duty >= MAX_D) begin
              state   <= HOLD;
              per_cnt <= '0;
            end else if (cnt_next(per_cnt) == RAMP_N) begin
              duty    <= duty + 4'd1;
              chg_p0  <= 1'b1;
              per_cnt <= '0;
              if (duty + 4'd1 == MAX_D) state <= HOLD;
            end else begin
              per_cnt <= cnt_next(per_cnt);
            end
          end
        end
        HOLD: begin
          if (period_end) begin
            if (!auto_en) begin
              state   <= IDLE;
              per_cnt <= '0;
            end else if (cnt_next(per_cnt) == HOLD_N) begin
              state   <= RAMP_DOWN;
              per_cnt <= '0;
            end else begin
              per_cnt <= cnt_next(per_cnt);
            end
          end
        end
        RAMP_DOWN: begin
          if (period_end) begin
            if (!auto_en) begin
              state   <= IDLE;
              per_cnt <= '0;
            end else if (duty == 4'd0) begin
              state   <= RAMP_UP;
              per_cnt <= '0;
            end else if (cnt_next(per_cnt) == RAMP_N) begin
              duty    <= duty - 4'd1;
              chg_p0  <= 1'b1;
              per_cnt <= '0;
              if (duty == 4'd1) state <= RAMP_UP;
            end else begin
              per_cnt <= cnt_next(per_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUTY_SCHED_DROP_CNT_EN
  // A lone request arriving anywhere but IDLE cannot be honoured and is counted.
  logic [3:0] drop_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      drop_cnt <= '0;
    else if (one_req && (state != IDLE) && (drop_cnt != 4'hF))
      drop_cnt <= drop_cnt + 4'd1;
  end
  assign bus.o_drop_cnt = drop_cnt;
`else
  assign bus.o_drop_cnt = 4'd0;
`endif

  assign bus.o_duty      = duty;
  assign bus.o_duty_load = load_p1;
  assign bus.o_state     = state;

endmodule

// File: tb/tb_duty_scheduler.sv
// Directed testbench for duty_scheduler: manual steps, saturation, drop/cancel, auto sweep, exit and reset.
module tb_duty_scheduler;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

`ifdef DUTY_SCHED_DROP_CNT_EN
  localparam logic [3:0] EXP_DROP = 4'd1;
`else
  localparam logic [3:0] EXP_DROP = 4'd0;
`endif

  duty_scheduler_if bus ();

  duty_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic period_pulse();
    bus.i_period_end = 1'b1;
    tick();
    bus.i_period_end = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic manual_step(input bit up);
    bus.i_inc_req = up;
    bus.i_dec_req = ~up;
    tick();
    bus.i_inc_req = 1'b0;
    bus.i_dec_req = 1'b0;
    idle(2);
    period_pulse();
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (bus.o_duty !== 4'd5) begin miscompares++; $display("FAIL rst_duty: got %0d expected 5", bus.o_duty); end
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL rst_load: got %0b expected 0", bus.o_duty_load); end
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_drop_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_drop: got %0d expected 0", bus.o_drop_cnt); end
    idle(2);
    rst = 1'b0;
    tick();
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL rel_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL rel_load: got %0b expected 0", bus.o_duty_load); end
  endtask

  task automatic test_manual_step();
    bus.i_inc_req = 1'b1;
    tick();
    bus.i_inc_req = 1'b0;
    vectors++; if (bus.o_state !== 3'd1) begin miscompares++; $display("FAIL man_pend: got %0d expected 1", bus.o_state); end
    idle(4);
    vectors++; if (bus.o_duty !== 4'd5) begin miscompares++; $display("FAIL man_hold: got %0d expected 5", bus.o_duty); end
    period_pulse();
    vectors++; if (bus.o_duty !== 4'd6) begin miscompares++; $display("FAIL man_duty: got %0d expected 6", bus.o_duty); end
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL man_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL man_load_early: got %0b expected 0", bus.o_duty_load); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b1) begin miscompares++; $display("FAIL man_load: got %0b expected 1", bus.o_duty_load); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL man_load_end: got %0b expected 0", bus.o_duty_load); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) manual_step(1'b1);
    vectors++; if (bus.o_duty !== 4'd10) begin miscompares++; $display("FAIL sat_reach_max: got %0d expected 10", bus.o_duty); end
    bus.i_inc_req = 1'b1;
    tick();
    bus.i_inc_req = 1'b0;
    idle(2);
    period_pulse();
    vectors++; if (bus.o_duty !== 4'd10) begin miscompares++; $display("FAIL sat_max_duty: got %0d expected 10", bus.o_duty); end
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL sat_max_state: got %0d expected 0", bus.o_state); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL sat_max_load: got %0b expected 0", bus.o_duty_load); end
    idle(2);
    for (int k = 0; k < 10; k++) manual_step(1'b0);
    vectors++; if (bus.o_duty !== 4'd0) begin miscompares++; $display("FAIL sat_reach_min: got %0d expected 0", bus.o_duty); end
    bus.i_dec_req = 1'b1;
    tick();
    bus.i_dec_req = 1'b0;
    idle(2);
    period_pulse();
    vectors++; if (bus.o_duty !== 4'd0) begin miscompares++; $display("FAIL sat_min_duty: got %0d expected 0", bus.o_duty); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL sat_min_load: got %0b expected 0", bus.o_duty_load); end
    idle(2);
  endtask

  task automatic test_cancel_drop();
    bus.i_inc_req = 1'b1;
    bus.i_dec_req = 1'b1;
    tick();
    bus.i_inc_req = 1'b0;
    bus.i_dec_req = 1'b0;
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL cancel_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_drop_cnt !== 4'd0) begin miscompares++; $display("FAIL cancel_drop: got %0d expected 0", bus.o_drop_cnt); end
    bus.i_inc_req = 1'b1;
    tick();
    vectors++; if (bus.o_state !== 3'd1) begin miscompares++; $display("FAIL drop_pend: got %0d expected 1", bus.o_state); end
    tick();
    bus.i_inc_req = 1'b0;
    idle(2);
    period_pulse();
    vectors++; if (bus.o_duty !== 4'd1) begin miscompares++; $display("FAIL drop_duty: got %0d expected 1", bus.o_duty); end
    vectors++; if (bus.o_drop_cnt !== EXP_DROP) begin miscompares++; $display("FAIL drop_cnt: got %0d expected %0d", bus.o_drop_cnt, EXP_DROP); end
    idle(3);
  endtask

  task automatic test_auto_sweep();
    do_reset();
    bus.i_auto_en = 1'b1;
    tick();
    vectors++; if (bus.o_state !== 3'd2) begin miscompares++; $display("FAIL sweep_enter: got %0d expected 2", bus.o_state); end
    idle(9);
    for (int i = 1; i <= 72; i++) begin
      period_pulse();
      case (i)
        3:  begin vectors++; if (bus.o_duty !== 4'd5 || bus.o_state !== 3'd2) begin miscompares++; $display("FAIL sweep_p3: got duty %0d state %0d expected 5/2", bus.o_duty, bus.o_state); end end
        4:  begin vectors++; if (bus.o_duty !== 4'd6 || bus.o_state !== 3'd2) begin miscompares++; $display("FAIL sweep_p4: got duty %0d state %0d expected 6/2", bus.o_duty, bus.o_state); end end
        20: begin vectors++; if (bus.o_duty !== 4'd10 || bus.o_state !== 3'd3) begin miscompares++; $display("FAIL sweep_p20: got duty %0d state %0d expected 10/3", bus.o_duty, bus.o_state); end end
        27: begin vectors++; if (bus.o_duty !== 4'd10 || bus.o_state !== 3'd3) begin miscompares++; $display("FAIL sweep_p27: got duty %0d state %0d expected 10/3", bus.o_duty, bus.o_state); end end
        28: begin vectors++; if (bus.o_duty !== 4'd10 || bus.o_state !== 3'd4) begin miscompares++; $display("FAIL sweep_p28: got duty %0d state %0d expected 10/4", bus.o_duty, bus.o_state); end end
        32: begin vectors++; if (bus.o_duty !== 4'd9 || bus.o_state !== 3'd4) begin miscompares++; $display("FAIL sweep_p32: got duty %0d state %0d expected 9/4", bus.o_duty, bus.o_state); end end
        67: begin vectors++; if (bus.o_duty !== 4'd1 || bus.o_state !== 3'd4) begin miscompares++; $display("FAIL sweep_p67: got duty %0d state %0d expected 1/4", bus.o_duty, bus.o_state); end end
        68: begin vectors++; if (bus.o_duty !== 4'd0 || bus.o_state !== 3'd2) begin miscompares++; $display("FAIL sweep_p68: got duty %0d state %0d expected 0/2", bus.o_duty, bus.o_state); end end
        72: begin vectors++; if (bus.o_duty !== 4'd1 || bus.o_state !== 3'd2) begin miscompares++; $display("FAIL sweep_p72: got duty %0d state %0d expected 1/2", bus.o_duty, bus.o_state); end end
        default: ;
      endcase
      tick();
      if (i == 4) begin
        vectors++; if (bus.o_duty_load !== 1'b1) begin miscompares++; $display("FAIL sweep_load: got %0b expected 1", bus.o_duty_load); end
      end
      idle(8);
    end
    bus.i_auto_en = 1'b0;
    idle(2);
  endtask

  task automatic test_auto_exit();
    do_reset();
    bus.i_auto_en = 1'b1;
    tick();
    idle(9);
    for (int i = 1; i <= 43; i++) begin
      period_pulse();
      if (i == 40) begin
        vectors++; if (bus.o_duty !== 4'd7 || bus.o_state !== 3'd4) begin miscompares++; $display("FAIL exit_p40: got duty %0d state %0d expected 7/4", bus.o_duty, bus.o_state); end
      end
      idle(9);
    end
    bus.i_auto_en = 1'b0;
    idle(3);
    vectors++; if (bus.o_state !== 3'd4) begin miscompares++; $display("FAIL exit_wait: got %0d expected 4", bus.o_state); end
    period_pulse();
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL exit_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_duty !== 4'd7) begin miscompares++; $display("FAIL exit_duty: got %0d expected 7", bus.o_duty); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL exit_load: got %0b expected 0", bus.o_duty_load); end
  endtask

  task automatic test_auto_at_max();
    do_reset();
    for (int k = 0; k < 5; k++) manual_step(1'b1);
    bus.i_auto_en = 1'b1;
    tick();
    vectors++; if (bus.o_state !== 3'd2) begin miscompares++; $display("FAIL max_enter: got %0d expected 2", bus.o_state); end
    idle(9);
    period_pulse();
    vectors++; if (bus.o_state !== 3'd3 || bus.o_duty !== 4'd10) begin miscompares++; $display("FAIL max_hold: got duty %0d state %0d expected 10/3", bus.o_duty, bus.o_state); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL max_load: got %0b expected 0", bus.o_duty_load); end
    bus.i_auto_en = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    bus.i_auto_en = 1'b1;
    tick();
    idle(9);
    for (int i = 1; i <= 12; i++) begin
      period_pulse();
      if (i < 12) idle(9);
    end
    vectors++; if (bus.o_duty !== 4'd8 || bus.o_state !== 3'd2) begin miscompares++; $display("FAIL mid_pre: got duty %0d state %0d expected 8/2", bus.o_duty, bus.o_state); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.o_duty !== 4'd5) begin miscompares++; $display("FAIL mid_duty: got %0d expected 5", bus.o_duty); end
    vectors++; if (bus.o_state !== 3'd0) begin miscompares++; $display("FAIL mid_state: got %0d expected 0", bus.o_state); end
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL mid_load: got %0b expected 0", bus.o_duty_load); end
    bus.i_auto_en = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();
    vectors++; if (bus.o_state !== 3'd0 || bus.o_duty !== 4'd5) begin miscompares++; $display("FAIL mid_rel: got duty %0d state %0d expected 5/0", bus.o_duty, bus.o_state); end
    tick();
    vectors++; if (bus.o_duty_load !== 1'b0) begin miscompares++; $display("FAIL mid_rel_load: got %0b expected 0", bus.o_duty_load); end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.i_inc_req    = 1'b0;
    bus.i_dec_req    = 1'b0;
    bus.i_auto_en    = 1'b0;
    bus.i_period_end = 1'b0;
    test_reset();
    test_manual_step();
    test_saturation();
    test_cancel_drop();
    test_auto_sweep();
    test_auto_exit();
    test_auto_at_max();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
